// File: rtl/count_monitor_3bit.sv
// Cycle-accurate checker for a W-bit up counter: predicts each next count, flags deviations,
// and captures the final count plus the number of wraps on every clear.
module count_monitor_3bit #(
    parameter int W  = 3,
    parameter int CW = 4
) (
    input  logic          CK,
    input  logic          R,
    input  logic          CLR,
    input  logic [W-1:0]  Q,
    output logic [W-1:0]  LAST,
    output logic [CW-1:0] LASTWRAP,
    output logic          PVALID,
    output logic [CW-1:0] WRAP,
    output logic          ERR,
    output logic          SYNCED
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [W-1:0]  Q_ONE    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  Q_MAX    = {W{1'b1}};
    localparam logic [W-1:0]  Q_ZERO   = {W{1'b0}};
    localparam logic [CW-1:0] WRAP_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] WRAP_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] WRAP_ZERO = {CW{1'b0}};

    state_t        state_q, state_d;
    logic [W-1:0]  exp_q, exp_d;
    logic [W-1:0]  last_q, last_d;
    logic [CW-1:0] lastwrap_q, lastwrap_d;
    logic          pvalid_q, pvalid_d;
    logic [CW-1:0] wrap_q, wrap_d;
    logic          err_q, err_d;
    logic          synced_q, synced_d;
    logic          mismatch_s;

    // Next-state computation for prediction, capture, wrap counting and tracking FSM.
    always_comb begin
        mismatch_s = (state_q == S_TRACK) && (Q != exp_q);
        exp_d      = CLR ? Q_ZERO : (Q + Q_ONE);
        err_d      = err_q | mismatch_s;
        last_d     = last_q;
        lastwrap_d = lastwrap_q;
        pvalid_d   = 1'b0;
        wrap_d     = wrap_q;
        state_d    = state_q;

        // A clear always captures and restarts the wrap count, taking priority over a wrap.
        if (CLR) begin
            last_d     = Q;
            lastwrap_d = wrap_q;
            pvalid_d   = 1'b1;
            wrap_d     = WRAP_ZERO;
        end else if ((state_q == S_TRACK) && (Q == Q_MAX) && (wrap_q != WRAP_MAX)) begin
            wrap_d = wrap_q + WRAP_ONE;
        end else begin
            wrap_d = wrap_q;
        end

        case (state_q)
            S_IDLE:  state_d = S_TRACK;
            S_TRACK: begin
                if (CLR) begin
                    state_d = S_TRACK;
                end else if (mismatch_s) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_TRACK;
                end
            end
            S_FAULT: begin
                if (CLR) begin
                    state_d = S_TRACK;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        synced_d = (state_d == S_TRACK);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CK) begin
        if (R) begin
            state_q    <= S_IDLE;
            exp_q      <= Q_ZERO;
            last_q     <= Q_ZERO;
            lastwrap_q <= WRAP_ZERO;
            pvalid_q   <= 1'b0;
            wrap_q     <= WRAP_ZERO;
            err_q      <= 1'b0;
            synced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            last_q     <= last_d;
            lastwrap_q <= lastwrap_d;
            pvalid_q   <= pvalid_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
            synced_q   <= synced_d;
        end
    end

    assign LAST     = last_q;
    assign LASTWRAP = lastwrap_q;
    assign PVALID   = pvalid_q;
    assign WRAP     = wrap_q;
    assign ERR      = err_q;
    assign SYNCED   = synced_q;

endmodule
